alu: RTL and testbench
======================

Name: alu

Overview:
- 8-bit combinational arithmetic/logic unit with a registered result.
- A 4-bit opcode `sel` selects one of 16 operations on operands A and B.
- The result is captured on the rising clock edge, giving one cycle of latency.
- Used as a general-purpose datapath ALU. There is no handshake; an operation is issued every cycle.

Parameters:
- none; the datapath width is fixed at 8 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- A  input  8  operand A, unsigned
- B  input  8  operand B, unsigned
- sel  input  4  operation select
- out  output  8  registered result
- carry  output  1  registered carry/borrow flag (present only with ALU_FLAGS_EN)
- zero  output  1  registered zero flag (present only with ALU_FLAGS_EN)

Behaviour:
- One clock; reset is synchronous and active-low.
- At each rising clk edge with rst_n=0: out=8'h00, carry=0, zero=0.
- At each rising clk edge with rst_n=1: out <= f(A,B,sel), sampled in the same edge. Latency is 1 cycle and throughput is 1 operation per cycle.
- A, B and sel may change every cycle. Only the values present at the edge matter.
- Operations (all unsigned, result truncated to 8 bits):
  - 0 ADD: A+B; carry = sum bit 8
  - 1 SUB: A-B, modulo 256; carry = borrow (A<B)
  - 2 MUL: low 8 bits of A*B; carry = |product[15:8]
  - 3 DIV: A/B integer quotient. If B=0: out=8'hFF, carry=1.
  - 4 SHL: A<<1; carry = A[7]
  - 5 SHR: A>>1 logical; carry = A[0]
  - 6 ROL: {A[6:0],A[7]}; carry=0
  - 7 ROR: {A[0],A[7:1]}; carry=0
  - 8 AND: A&B
  - 9 OR: A|B
  - A XOR: A^B
  - B NOR: ~(A|B)
  - C NAND: ~(A&B)
  - D XNOR: ~(A^B)
  - E GT: 8'h01 if A>B, else 8'h00
  - F EQ: 8'h01 if A==B, else 8'h00
- carry=0 for ops 6–F.
- zero=1 when the 8-bit result is 0, for every op.
- B is ignored for ops 4–7.
- No X propagation: every sel value is decoded, so there is no default-to-X case.
- Reset mid-stream: the output is cleared on the reset edge. The first valid result appears the cycle after rst_n returns high with valid inputs.
- sel wrap from F to 0 is an ordinary opcode change with no special handling.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: carry and zero ports exist and are registered alongside out with identical reset and latency.
- Undefined: carry and zero ports and their logic are absent. out behaviour is unchanged, including DIV by zero giving 8'hFF.

Test Plan:
- Reset check: hold rst_n=0 for 2 edges with A=8'h0A, B=8'h02 -> out=8'h00, carry=0, zero=0.
- Opcode sweep with A=8'h0A, B=8'h02, sel stepping 1..F then 0, one per cycle; each result checked one cycle later:
  - sel 1..7 -> 08, 14, 05, 14, 05, 14, 05
  - sel 8..F -> 02, 0A, 08, F5, FD, F7, 01, 00
  - sel 0 -> 0C
- Overflow with A=8'hF6, B=8'h0A:
  - ADD -> out=00, carry=1, zero=1
  - SUB -> EC, carry=0
  - MUL -> 9C, carry=1
  - DIV -> 18
  - GT -> 01
- Divide by zero: A=8'h55, B=8'h00, sel=3 -> out=8'hFF, carry=1. Borrow: A=8'h02, B=8'h05, sel=1 -> out=8'hFD, carry=1.
- Shifts/rotates with A=8'h81:
  - SHL -> 02, carry=1
  - SHR -> 40, carry=1
  - ROL -> 03
  - ROR -> C0
- Mid-operation reset: drive ADD continuously, assert rst_n=0 for one edge -> out=00 at that edge. Deassert -> the correct sum appears on the following edge.

Source files
------------

// File: rtl/alu.sv
// 8-bit, 16-operation ALU; the result is registered, so latency is 1 cycle. There is no handshake: one operation per cycle.
// Define ALU_FLAGS_EN to add registered carry/borrow and zero flags alongside the result.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] sel,
`ifdef ALU_FLAGS_EN
  output logic       carry,
  output logic       zero,
`endif
  output logic [7:0] out
);

  logic [7:0] out_d, out_q;

  always_comb begin
    out_d = 8'h00;
    case (sel)
      4'h0: out_d = A + B;
      4'h1: out_d = A - B;
      4'h2: out_d = A * B;
      4'h3: out_d = (B == 8'h00) ? 8'hFF : A / B;
      4'h4: out_d = A << 1;
      4'h5: out_d = A >> 1;
      4'h6: out_d = {A[6:0], A[7]};
      4'h7: out_d = {A[0], A[7:1]};
      4'h8: out_d = A & B;
      4'h9: out_d = A | B;
      4'hA: out_d = A ^ B;
      4'hB: out_d = ~(A | B);
      4'hC: out_d = ~(A & B);
      4'hD: out_d = ~(A ^ B);
      4'hE: out_d = {7'h00, A > B};
      4'hF: out_d = {7'h00, A == B};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_q <= 8'h00;
    else        out_q <= out_d;
  end

  assign out = out_q;

`ifdef ALU_FLAGS_EN
  logic carry_d, carry_q;
  logic zero_d, zero_q;

  // Overflow is detected by magnitude compare on the widened result.
  always_comb begin
    carry_d = 1'b0;
    case (sel)
      4'h0:    carry_d = ({1'b0, A} + {1'b0, B}) > 9'd255;
      4'h1:    carry_d = A < B;
      4'h2:    carry_d = ({8'h00, A} * {8'h00, B}) > 16'd255;
      4'h3:    carry_d = B == 8'h00;
      4'h4:    carry_d = A[7];
      4'h5:    carry_d = A[0];
      default: carry_d = 1'b0;
    endcase
    zero_d = (out_d == 8'h00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry = carry_q;
  assign zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu; flag checks are compiled in only with ALU_FLAGS_EN.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] sel;
  logic [7:0] out;
`ifdef ALU_FLAGS_EN
  logic       carry;
  logic       zero;
`endif

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .sel   (sel),
`ifdef ALU_FLAGS_EN
    .carry (carry),
    .zero  (zero),
`endif
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Drive one operation and sample the result 1 time unit after the capturing edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    A   = a;
    B   = b;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [16];

  initial begin
    sweep_exp[0]  = 8'h0C; sweep_exp[1]  = 8'h08; sweep_exp[2]  = 8'h14; sweep_exp[3]  = 8'h05;
    sweep_exp[4]  = 8'h14; sweep_exp[5]  = 8'h05; sweep_exp[6]  = 8'h14; sweep_exp[7]  = 8'h05;
    sweep_exp[8]  = 8'h02; sweep_exp[9]  = 8'h0A; sweep_exp[10] = 8'h08; sweep_exp[11] = 8'hF5;
    sweep_exp[12] = 8'hFD; sweep_exp[13] = 8'hF7; sweep_exp[14] = 8'h01; sweep_exp[15] = 8'h00;

    // Reset held for two edges
    rst_n = 1'b0;
    apply(8'h0A, 8'h02, 4'h0);
    apply(8'h0A, 8'h02, 4'h0);
    check("reset_out", out, 8'h00);
`ifdef ALU_FLAGS_EN
    check("reset_carry", {7'h00, carry}, 8'h00);
    check("reset_zero", {7'h00, zero}, 8'h00);
`endif
    rst_n = 1'b1;

    // Opcode sweep 1..F then wrap to 0
    for (int i = 1; i <= 16; i++) begin
      apply(8'h0A, 8'h02, 4'(i));
      check($sformatf("sweep_sel%0h", i % 16), out, sweep_exp[i % 16]);
`ifdef ALU_FLAGS_EN
      check($sformatf("sweep_zero%0h", i % 16), {7'h00, zero}, {7'h00, sweep_exp[i % 16] == 8'h00});
`endif
    end

    // Overflow cases
    apply(8'hF6, 8'h0A, 4'h0);
    check("ovf_add", out, 8'h00);
`ifdef ALU_FLAGS_EN
    check("ovf_add_carry", {7'h00, carry}, 8'h01);
    check("ovf_add_zero", {7'h00, zero}, 8'h01);
`endif
    apply(8'hF6, 8'h0A, 4'h1);
    check("ovf_sub", out, 8'hEC);
`ifdef ALU_FLAGS_EN
    check("ovf_sub_carry", {7'h00, carry}, 8'h00);
`endif
    apply(8'hF6, 8'h0A, 4'h2);
    check("ovf_mul", out, 8'h9C);
`ifdef ALU_FLAGS_EN
    check("ovf_mul_carry", {7'h00, carry}, 8'h01);
`endif
    apply(8'hF6, 8'h0A, 4'h3);
    check("ovf_div", out, 8'h18);
    apply(8'hF6, 8'h0A, 4'hE);
    check("ovf_gt", out, 8'h01);

    // Divide by zero and borrow
    apply(8'h55, 8'h00, 4'h3);
    check("div0", out, 8'hFF);
`ifdef ALU_FLAGS_EN
    check("div0_carry", {7'h00, carry}, 8'h01);
`endif
    apply(8'h02, 8'h05, 4'h1);
    check("borrow", out, 8'hFD);
`ifdef ALU_FLAGS_EN
    check("borrow_carry", {7'h00, carry}, 8'h01);
`endif

    // Shifts and rotates; B is deliberately non-zero to show it is ignored
    apply(8'h81, 8'h33, 4'h4);
    check("shl", out, 8'h02);
`ifdef ALU_FLAGS_EN
    check("shl_carry", {7'h00, carry}, 8'h01);
`endif
    apply(8'h81, 8'h33, 4'h5);
    check("shr", out, 8'h40);
`ifdef ALU_FLAGS_EN
    check("shr_carry", {7'h00, carry}, 8'h01);
`endif
    apply(8'h81, 8'h33, 4'h6);
    check("rol", out, 8'h03);
`ifdef ALU_FLAGS_EN
    check("rol_carry", {7'h00, carry}, 8'h00);
`endif
    apply(8'h81, 8'h33, 4'h7);
    check("ror", out, 8'hC0);

    // Reset in the middle of a stream of ADDs
    apply(8'h10, 8'h20, 4'h0);
    check("stream_add", out, 8'h30);
    rst_n = 1'b0;
    apply(8'h10, 8'h20, 4'h0);
    check("midrst_out", out, 8'h00);
`ifdef ALU_FLAGS_EN
    check("midrst_zero", {7'h00, zero}, 8'h00);
`endif
    rst_n = 1'b1;
    apply(8'h03, 8'h04, 4'h0);
    check("post_rst_add", out, 8'h07);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
